// File: rtl/time_set_ctrl.sv
// Time-of-day set controller: power/run/set-mode sequencing, 1 Hz count
// enables, add/sub field pulses with hold-to-repeat, and field blink.
// Every output is a register loaded from the current state and inputs.
module time_set_ctrl #(
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       power,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       add_btn,
    input  logic       sub_btn,
    input  logic       sec_end,
    input  logic       min_end,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic [2:0] add_sel,
    output logic [2:0] sub_sel,
    output logic       timer_reset,
    output logic [2:0] state,
    output logic       blink
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_RUN      = 3'd1,
        S_SET_SEC  = 3'd2,
        S_SET_MIN  = 3'd3,
        S_SET_HOUR = 3'd4
    } state_t;

    state_t             cur_state;
    state_t             nxt_state;

    logic               mode_prev;
    logic               add_prev;
    logic               sub_prev;
    logic               mode_edge;
    logic               add_edge;
    logic               sub_edge;

    // hold_cnt == 0 means no hold is being tracked; rep_active selects
    // the repeat period instead of the initial delay
    logic [CNT_W-1:0]   hold_cnt;
    logic               rep_active;
    logic [CNT_W-1:0]   nxt_hold_cnt;
    logic               nxt_rep_active;

    logic               in_set;
    logic [2:0]         field_sel;
    logic               press_edge;
    logic               rep_fire;

    logic               nxt_sec_en;
    logic               nxt_min_en;
    logic               nxt_hour_en;
    logic [2:0]         nxt_add_sel;
    logic [2:0]         nxt_sub_sel;
    logic               nxt_timer_reset;
    logic               nxt_blink;

    assign state     = cur_state;
    assign mode_edge = mode_btn & ~mode_prev;
    assign add_edge  = add_btn & ~add_prev;
    assign sub_edge  = sub_btn & ~sub_prev;

    // State, edge history, hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state   <= S_OFF;
            mode_prev   <= 1'b0;
            add_prev    <= 1'b0;
            sub_prev    <= 1'b0;
            hold_cnt    <= '0;
            rep_active  <= 1'b0;
            sec_en      <= 1'b0;
            min_en      <= 1'b0;
            hour_en     <= 1'b0;
            add_sel     <= 3'b000;
            sub_sel     <= 3'b000;
            timer_reset <= 1'b1;
            blink       <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            // Edge history is held clear while off so power-up starts fresh
            if (cur_state == S_OFF) begin
                mode_prev <= 1'b0;
                add_prev  <= 1'b0;
                sub_prev  <= 1'b0;
            end else begin
                mode_prev <= mode_btn;
                add_prev  <= add_btn;
                sub_prev  <= sub_btn;
            end
            hold_cnt    <= nxt_hold_cnt;
            rep_active  <= nxt_rep_active;
            sec_en      <= nxt_sec_en;
            min_en      <= nxt_min_en;
            hour_en     <= nxt_hour_en;
            add_sel     <= nxt_add_sel;
            sub_sel     <= nxt_sub_sel;
            timer_reset <= nxt_timer_reset;
            blink       <= nxt_blink;
        end
    end

    // Next state, hold-to-repeat and next output values
    always_comb begin
        nxt_state       = S_OFF;
        nxt_hold_cnt    = '0;
        nxt_rep_active  = 1'b0;
        nxt_add_sel     = 3'b000;
        nxt_sub_sel     = 3'b000;
        nxt_blink       = 1'b0;
        in_set          = 1'b0;
        field_sel       = 3'b000;

        case (cur_state)
            S_SET_SEC:  begin in_set = 1'b1; field_sel = 3'b001; end
            S_SET_MIN:  begin in_set = 1'b1; field_sel = 3'b010; end
            S_SET_HOUR: begin in_set = 1'b1; field_sel = 3'b100; end
            default:    begin in_set = 1'b0; field_sel = 3'b000; end
        endcase

        if (power) begin
            case (cur_state)
                S_OFF:      nxt_state = S_RUN;
                S_RUN:      nxt_state = mode_edge ? S_SET_SEC  : S_RUN;
                S_SET_SEC:  nxt_state = mode_edge ? S_SET_MIN  : S_SET_SEC;
                S_SET_MIN:  nxt_state = mode_edge ? S_SET_HOUR : S_SET_MIN;
                S_SET_HOUR: nxt_state = mode_edge ? S_RUN      : S_SET_HOUR;
                default:    nxt_state = S_OFF;
            endcase
        end

        nxt_sec_en      = power & (cur_state == S_RUN) & tick;
        nxt_min_en      = nxt_sec_en & sec_end;
        nxt_hour_en     = nxt_min_en & min_end;
        nxt_timer_reset = (nxt_state == S_OFF);

        press_edge = add_btn ? add_edge : sub_edge;
        rep_fire   = rep_active ? (hold_cnt == CNT_W'(REPEAT_PERIOD))
                                : (hold_cnt == CNT_W'(REPEAT_DELAY));

        // Exactly one of add/sub held; a mode edge or both buttons cancel it
        if (power && in_set && !mode_edge && (add_btn ^ sub_btn)) begin
            if (press_edge) begin
                nxt_hold_cnt = CNT_W'(1);
                if (add_btn) nxt_add_sel = field_sel;
                else         nxt_sub_sel = field_sel;
            end else if (hold_cnt != '0) begin
                if (rep_fire) begin
                    nxt_hold_cnt   = CNT_W'(1);
                    nxt_rep_active = 1'b1;
                    if (add_btn) nxt_add_sel = field_sel;
                    else         nxt_sub_sel = field_sel;
                end else begin
                    nxt_hold_cnt   = hold_cnt + CNT_W'(1);
                    nxt_rep_active = rep_active;
                end
            end
        end

        // Blink only runs while staying in the same set mode
        if (in_set && (nxt_state == cur_state)) begin
            nxt_blink = blink ^ tick;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed vector table, corner-case sequences
// and randomized stimulus compared against a behavioural model.
module tb_time_set_ctrl;

    localparam int D = 8;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       power = 1'b0;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       add_btn = 1'b0;
    logic       sub_btn = 1'b0;
    logic       sec_end = 1'b0;
    logic       min_end = 1'b0;
    logic       sec_en, min_en, hour_en, timer_reset, blink;
    logic [2:0] add_sel, sub_sel, state;

    time_set_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .clk(clk), .reset_n(reset_n), .power(power), .tick(tick),
        .mode_btn(mode_btn), .add_btn(add_btn), .sub_btn(sub_btn),
        .sec_end(sec_end), .min_end(min_end),
        .sec_en(sec_en), .min_en(min_en), .hour_en(hour_en),
        .add_sel(add_sel), .sub_sel(sub_sel), .timer_reset(timer_reset),
        .state(state), .blink(blink)
    );

    always #5 clk = ~clk;

    // {state, timer_reset, sec_en, min_en, hour_en, add_sel, sub_sel, blink}
    logic [13:0] dut_out;
    assign dut_out = {state, timer_reset, sec_en, min_en, hour_en, add_sel, sub_sel, blink};

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(string name, logic [13:0] act, logic [13:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Behavioural model: state as an integer mode index, hold tracked as
    // cycles elapsed since the press edge (-1 when idle)
    int          m_st   = 0;
    bit          m_mp   = 0, m_ap = 0, m_sp = 0;
    int          m_held = -1;
    bit          m_bl   = 0;
    logic [13:0] exp_out;

    task automatic model_eval();
        int nst;
        bit set, medge, aedge, sedge, pe, fire;
        logic [2:0] fld, en, a_o, s_o;
        if (!reset_n) begin
            m_st = 0; m_mp = 0; m_ap = 0; m_sp = 0; m_held = -1; m_bl = 0;
            exp_out = {3'd0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0};
            return;
        end
        set   = (m_st >= 2 && m_st <= 4);
        medge = mode_btn && !m_mp;
        aedge = add_btn && !m_ap;
        sedge = sub_btn && !m_sp;
        if (!power)            nst = 0;
        else if (m_st == 0)    nst = 1;
        else if (m_st > 4)     nst = 0;
        else if (medge)        nst = (m_st == 4) ? 1 : m_st + 1;
        else                   nst = m_st;
        en  = (power && m_st == 1 && tick) ? {1'b1, sec_end, sec_end && min_end} : 3'b000;
        a_o = 3'b000;
        s_o = 3'b000;
        fire = 0;
        if (power && set && !medge && (add_btn != sub_btn)) begin
            fld = 3'(1 << (m_st - 2));
            pe  = add_btn ? aedge : sedge;
            if (pe) begin
                fire = 1;
                m_held = 0;
            end else if (m_held >= 0) begin
                m_held++;
                fire = (m_held == D) || (m_held > D && ((m_held - D) % P) == 0);
            end
            if (fire) begin
                if (add_btn) a_o = fld;
                else         s_o = fld;
            end
        end else begin
            m_held = -1;
        end
        if (nst != m_st || !set) m_bl = 0;
        else if (tick)           m_bl = !m_bl;
        if (m_st == 0) begin
            m_mp = 0; m_ap = 0; m_sp = 0;
        end else begin
            m_mp = mode_btn; m_ap = add_btn; m_sp = sub_btn;
        end
        m_st = nst;
        exp_out = {3'(nst), (nst == 0), en, a_o, s_o, m_bl};
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic mode_press();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    typedef struct {
        bit rn, pw, tk, md, ad, sb, se, me;
        logic [2:0] st;
        bit tr;
        logic [2:0] en, as, ss;
        bit bl;
    } vec_t;

    localparam int NV = 24;
    vec_t vec[NV];

    initial begin
        logic [2:0] exp_as;
        //          rn pw tk md ad sb se me | st tr en  as  ss  bl
        vec[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 3'b000, 3'b000, 3'b000, 0};
        vec[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[2]  = '{1, 1, 1, 0, 0, 0, 0, 0, 3'd1, 0, 3'b100, 3'b000, 3'b000, 0};
        vec[3]  = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[4]  = '{1, 1, 1, 0, 0, 0, 1, 1, 3'd1, 0, 3'b111, 3'b000, 3'b000, 0};
        vec[5]  = '{1, 1, 1, 0, 0, 0, 1, 0, 3'd1, 0, 3'b110, 3'b000, 3'b000, 0};
        vec[6]  = '{1, 1, 0, 1, 0, 0, 0, 0, 3'd2, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[7]  = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd2, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[8]  = '{1, 1, 0, 1, 1, 0, 0, 0, 3'd3, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[9]  = '{1, 1, 0, 0, 1, 0, 0, 0, 3'd3, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd3, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 3'd3, 0, 3'b000, 3'b000, 3'b000, 1};
        vec[12] = '{1, 1, 0, 0, 1, 0, 0, 0, 3'd3, 0, 3'b000, 3'b010, 3'b000, 1};
        vec[13] = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd3, 0, 3'b000, 3'b000, 3'b000, 1};
        vec[14] = '{1, 1, 0, 0, 0, 1, 0, 0, 3'd3, 0, 3'b000, 3'b000, 3'b010, 1};
        vec[15] = '{1, 1, 1, 0, 0, 0, 0, 0, 3'd3, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[16] = '{1, 1, 0, 1, 0, 0, 0, 0, 3'd4, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[17] = '{1, 1, 1, 0, 0, 0, 0, 0, 3'd4, 0, 3'b000, 3'b000, 3'b000, 1};
        vec[18] = '{1, 1, 0, 1, 0, 0, 0, 0, 3'd1, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[19] = '{1, 1, 0, 0, 1, 0, 0, 0, 3'd1, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[20] = '{1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 1, 3'b000, 3'b000, 3'b000, 0};
        vec[21] = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 3'b000, 3'b000, 3'b000, 0};
        vec[22] = '{1, 0, 1, 1, 0, 0, 0, 0, 3'd0, 1, 3'b000, 3'b000, 3'b000, 0};
        vec[23] = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd1, 0, 3'b000, 3'b000, 3'b000, 0};

        for (int i = 0; i < NV; i++) begin
            reset_n  = vec[i].rn; power   = vec[i].pw; tick    = vec[i].tk;
            mode_btn = vec[i].md; add_btn = vec[i].ad; sub_btn = vec[i].sb;
            sec_end  = vec[i].se; min_end = vec[i].me;
            step();
            check($sformatf("vec%0d", i), dut_out,
                  {vec[i].st, vec[i].tr, vec[i].en, vec[i].as, vec[i].ss, vec[i].bl});
        end
        tick = 0; sec_end = 0; min_end = 0;

        // Hold-to-repeat in SET_HOUR: pulses 1, 9, 13, 17 cycles after press
        mode_press(); mode_press(); mode_press();
        check("to_set_hour", {11'd0, state}, {11'd0, 3'd4});
        add_btn = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            exp_as = (j == 1 || j == 9 || j == 13 || j == 17) ? 3'b100 : 3'b000;
            check($sformatf("rep_hour%0d", j), {11'd0, add_sel}, {11'd0, exp_as});
        end
        add_btn = 1'b0;
        step();
        add_btn = 1'b1; sub_btn = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            check($sformatf("both%0d", j), {8'd0, add_sel, sub_sel}, 14'd0);
        end
        add_btn = 1'b0; sub_btn = 1'b0;
        step();

        // Power drop while holding add in SET_SEC
        mode_press(); mode_press();
        check("to_set_sec", {11'd0, state}, {11'd0, 3'd2});
        add_btn = 1'b1;
        step();
        check("sec_press", {11'd0, add_sel}, {11'd0, 3'b001});
        step(); step(); step();
        power = 1'b0;
        step();
        check("pwr_off", {7'd0, state, timer_reset, add_sel}, {7'd0, 3'd0, 1'b1, 3'b000});
        power = 1'b1;
        step();
        check("pwr_on", {7'd0, state, timer_reset, add_sel}, {7'd0, 3'd1, 1'b0, 3'b000});
        mode_btn = 1'b1;
        step();
        check("pwr_set", {8'd0, state, add_sel}, {8'd0, 3'd2, 3'b000});
        mode_btn = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("no_spur%0d", j), {11'd0, add_sel}, 14'd0);
        end
        add_btn = 1'b0;
        step();

        // Reset in the middle of an auto-repeat
        add_btn = 1'b1;
        step();
        check("mid_press", {11'd0, add_sel}, {11'd0, 3'b001});
        for (int j = 2; j <= 10; j++) step();
        reset_n = 1'b0;
        step();
        check("mid_reset", dut_out, {3'd0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0});
        reset_n = 1'b1;
        step();
        check("rst_run", {8'd0, state, add_sel}, {8'd0, 3'd1, 3'b000});
        mode_press();
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("rst_nospur%0d", j), {8'd0, state, add_sel}, {8'd0, 3'd2, 3'b000});
        end
        add_btn = 1'b0;
        step();
        add_btn = 1'b1;
        step();
        check("new_press", {11'd0, add_sel}, {11'd0, 3'b001});
        add_btn = 1'b0;

        // Randomized run against the model
        reset_n = 1'b0;
        step();
        check("rand_rst", dut_out, exp_out);
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            power   = ($urandom_range(0, 149) != 0);
            tick    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0)  mode_btn = ~mode_btn;
            if ($urandom_range(0, 14) == 0) add_btn  = ~add_btn;
            if ($urandom_range(0, 14) == 0) sub_btn  = ~sub_btn;
            sec_end = 1'($urandom_range(0, 1));
            min_end = 1'($urandom_range(0, 1));
            step();
            check($sformatf("rand%0d", c), dut_out, exp_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
